// File: rtl/nios_ii_base_onchip_ram_ctrl.sv
// nios_ii_base_onchip_ram_ctrl: on-chip RAM slave with zero-fill after reset,
// byte-lane writes, pipelined reads (latency 1 or 2) and a sticky range flag.
// Ports:
//   clk, reset_n           - clock, asynchronous active-low reset
//   address, byteenable    - word address, write lane enables
//   chipselect, read, write, writedata - slave request
//   clken                  - clock enable, low freezes the block
//   readdata, readdatavalid - read response
//   waitrequest, init_done  - stall, zero-fill complete
//   range_err               - sticky out-of-range access flag
module nios_ii_base_onchip_ram_ctrl #(
  parameter int DATA_WIDTH     = 64,
  parameter int ADDR_WIDTH     = 14,
  parameter int DEPTH          = 16000,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic                    chipselect,
  input  logic                    read,
  input  logic                    write,
  input  logic [DATA_WIDTH-1:0]   writedata,
  input  logic                    clken,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic                    readdatavalid,
  output logic                    waitrequest,
  output logic                    init_done,
  output logic                    range_err
);
  localparam int NB = DATA_WIDTH / 8;
  typedef enum logic {CLEAR, READY} state_t;
  localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : READY;
  state_t                  r_state, w_next;
  logic [ADDR_WIDTH-1:0]   r_clr_addr, w_clr_next;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
  logic [DATA_WIDTH-1:0]   r_q, r_d2, r_hold, w_cur;
  logic                    r_v0, r_v1, r_oor0, r_range_err;
  logic                    w_oor, w_acc, w_wr_acc, w_rd_acc, w_clr_we, w_vld;
  assign waitrequest = (r_state == CLEAR) | ~clken;
  assign init_done   = (r_state == READY) & reset_n;
  assign w_oor       = {1'b0, address} >= (ADDR_WIDTH+1)'(DEPTH);
  assign w_acc       = chipselect & (read | write) & ~waitrequest & reset_n;
  assign w_wr_acc    = w_acc & write;
  assign w_rd_acc    = w_acc & read & ~write;
  assign w_clr_we    = (r_state == CLEAR) & clken & reset_n;
  // A completed read is only presented in a cycle the block is enabled
  assign w_vld         = ((READ_LATENCY == 2) ? r_v1 : r_v0) & clken;
  assign w_cur         = (READ_LATENCY == 2) ? r_d2 : (r_oor0 ? '0 : r_q);
  assign readdatavalid = w_vld;
  assign readdata      = w_vld ? w_cur : r_hold;
  assign range_err     = r_range_err;
  always_comb begin
    w_next     = r_state;
    w_clr_next = r_clr_addr;
    if (r_state == CLEAR && clken) begin
      w_clr_next = r_clr_addr + ADDR_WIDTH'(1);
      if (r_clr_addr == ADDR_WIDTH'(DEPTH - 1)) begin
        w_next     = READY;
        w_clr_next = '0;
      end
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= RST_STATE;
      r_clr_addr <= '0;
    end else begin
      r_state    <= w_next;
      r_clr_addr <= w_clr_next;
    end
  end
  // Block RAM: single port, synchronous read, no reset on contents
  always_ff @(posedge clk) begin
    if (w_clr_we) r_mem[r_clr_addr] <= '0;
    else if (w_wr_acc && !w_oor)
      for (int i = 0; i < NB; i++)
        if (byteenable[i]) r_mem[address][8*i +: 8] <= writedata[8*i +: 8];
    if (w_rd_acc) r_q <= r_mem[address];
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_v0        <= 1'b0;
      r_v1        <= 1'b0;
      r_oor0      <= 1'b0;
      r_d2        <= '0;
      r_hold      <= '0;
      r_range_err <= 1'b0;
    end else if (clken) begin
      r_v0   <= w_rd_acc;
      r_oor0 <= w_oor;
      r_v1   <= r_v0;
      r_d2   <= r_oor0 ? '0 : r_q;
      if (w_vld) r_hold <= w_cur;
      if (w_acc && w_oor) r_range_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_nios_ii_base_onchip_ram_ctrl.sv
// tb_nios_ii_base_onchip_ram_ctrl: randomized bench with behavioural RAM model.
module tb_nios_ii_base_onchip_ram_ctrl;
  localparam int DEPTH = 16000;
  localparam int LAT   = 2;
  logic        clk = 0, reset_n = 0;
  logic [13:0] address = '0;
  logic [7:0]  byteenable = '0;
  logic        chipselect = 0, read = 0, write = 0, clken = 1;
  logic [63:0] writedata = '0;
  logic [63:0] readdata;
  logic        readdatavalid, waitrequest, init_done, range_err;
  int checks = 0, failures = 0;

  nios_ii_base_onchip_ram_ctrl #(.READ_LATENCY(LAT)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
    .clken(clken), .readdata(readdata), .readdatavalid(readdatavalid),
    .waitrequest(waitrequest), .init_done(init_done), .range_err(range_err));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 30) $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: array memory, clear countdown, queue of pending reads
  typedef struct {logic [63:0] d; int t;} pend_t;
  pend_t       pq[$];
  logic [63:0] m_mem [DEPTH];
  logic [63:0] m_last = '0;
  bit          m_clear = 1, m_rerr = 0;
  int          m_left = DEPTH, en_cnt = 0;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_clear = 1; m_left = DEPTH; pq.delete(); m_last = '0; m_rerr = 0;
    end else if (clken) begin
      en_cnt++;
      if (pq.size() > 0 && pq[0].t == en_cnt) begin
        m_last = pq[0].d;
        void'(pq.pop_front());
      end
      if (m_clear) begin
        m_left--;
        if (m_left == 0) begin
          m_clear = 0;
          foreach (m_mem[i]) m_mem[i] = '0;
        end
      end else if (chipselect && (read || write)) begin
        bit oor;
        oor = int'(address) >= DEPTH;
        if (oor) m_rerr = 1;
        if (write) begin
          if (!oor)
            for (int b = 0; b < 8; b++)
              if (byteenable[b]) m_mem[address][8*b +: 8] = writedata[8*b +: 8];
        end else pq.push_back('{oor ? 64'h0 : m_mem[address], en_cnt + LAT});
      end
    end
  end

  always @(negedge clk) begin
    bit ev;
    ev = reset_n && clken && pq.size() > 0 && pq[0].t == en_cnt + 1;
    chk("valid", readdatavalid, ev);
    chk("readdata", readdata, ev ? pq[0].d : (reset_n ? m_last : 64'h0));
    chk("waitrequest", waitrequest, !reset_n ? 1'b1 : (m_clear || !clken));
    chk("init_done", init_done, reset_n && !m_clear);
    chk("range_err", range_err, reset_n ? m_rerr : 1'b0);
  end

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic idle(); chipselect = 0; read = 0; write = 0; endtask

  task automatic wr(input int a, input logic [63:0] d, input logic [7:0] be);
    chipselect = 1; write = 1; read = 0; address = 14'(a); writedata = d; byteenable = be;
    tick(); idle();
  endtask

  task automatic rd_lit(input string nm, input int a, input logic [63:0] exp);
    bit got = 0;
    chipselect = 1; read = 1; write = 0; address = 14'(a);
    tick(); idle();
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (readdatavalid) got = 1; else tick();
    end
    chk({nm, "_seen"}, got, 1'b1);
    chk(nm, readdata, exp);
    tick();
  endtask

  task automatic count_clear(input string nm);
    int wc = 0;
    while (waitrequest && wc < 20000) begin wc++; tick(); end
    chk(nm, wc, DEPTH);
  endtask

  initial begin
    logic        v[8];
    logic [63:0] d[8];
    repeat (3) tick();
    chk("rst_waitrequest", waitrequest, 1'b1);
    chk("rst_init_done", init_done, 1'b0);
    reset_n = 1;
    count_clear("clear_len");
    chk("init_after_clear", init_done, 1'b1);
    rd_lit("clear_rd0", 0, 64'h0);
    rd_lit("clear_rd_last", DEPTH - 1, 64'h0);
    wr(5, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    wr(5, 64'h1122_3344_5566_7788, 8'h0F);
    rd_lit("byte_lanes", 5, 64'hFFFF_FFFF_5566_7788);
    wr(1, 64'hA1, 8'hFF); wr(2, 64'hB2, 8'hFF); wr(3, 64'hC3, 8'hFF);
    for (int i = 0; i < 6; i++) begin
      if (i < 3) begin chipselect = 1; read = 1; address = 14'(i + 1); end else idle();
      @(negedge clk); v[i] = readdatavalid; d[i] = readdata;
      tick();
    end
    idle();
    chk("lat_v0", {v[0], v[1], v[2], v[3], v[4], v[5]}, 6'b001110);
    chk("lat_d1", d[2], 64'hA1); chk("lat_d2", d[3], 64'hB2); chk("lat_d3", d[4], 64'hC3);
    wr(7, 64'hDEAD_BEEF_0000_0007, 8'hFF);
    for (int i = 0; i < 8; i++) begin
      clken = !(i >= 1 && i <= 3);
      if (i == 0) begin chipselect = 1; read = 1; address = 14'd7; end else idle();
      @(negedge clk); v[i] = readdatavalid; d[i] = readdata;
      tick();
    end
    clken = 1;
    chk("stall_v", {v[0], v[1], v[2], v[3], v[4], v[5], v[6], v[7]}, 8'b00000100);
    chk("stall_d", d[5], 64'hDEAD_BEEF_0000_0007);
    chk("rerr_before", range_err, 1'b0);
    wr(DEPTH, 64'hAB, 8'hFF);
    chk("rerr_set", range_err, 1'b1);
    rd_lit("oor_rd", DEPTH, 64'h0);
    rd_lit("oor_neighbor", DEPTH - 1, 64'h0);
    for (int n = 0; n < 3000; n++) begin
      int op, sel;
      clken = $urandom_range(0, 9) != 0;
      chipselect = $urandom_range(0, 3) != 0;
      op = $urandom_range(0, 4);
      read = op < 2 || op == 4;
      write = op >= 2;
      sel = $urandom_range(0, 9);
      address = sel < 7 ? 14'($urandom_range(0, 31))
              : sel < 9 ? 14'($urandom_range(DEPTH - 4, DEPTH - 1))
              : 14'($urandom_range(DEPTH, 16383));
      writedata = {$urandom, $urandom};
      byteenable = 8'($urandom);
      tick();
    end
    clken = 1; idle();
    tick();
    chk("rerr_held", range_err, 1'b1);
    chipselect = 1; read = 1; address = 14'd3;
    tick();
    reset_n = 0; idle();
    @(negedge clk);
    chk("flight_discard", readdatavalid, 1'b0);
    chk("rerr_reset", range_err, 1'b0);
    tick(); tick();
    reset_n = 1;
    repeat (100) tick();
    reset_n = 0;
    tick(); tick();
    reset_n = 1;
    count_clear("restart_clear_len");
    rd_lit("restart_rd", 5, 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
